dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory (dmemip) between the core load/store path and the
//  coprocessor IO port. Grants one access per cycle: core has fixed priority, with a
//  starvation guard and a coprocessor lock (burst) mode. Routes the 1-cycle-latency read
//  data back to its owner. Sits between core datapath, coprocessor IO pins and dmemip.
// PARAMETERS
//  N          64  data width
//  AW         8   dmem word-address width (byte addr bits [AW+2:3])
//  STARVE_MAX 4   consecutive lost cycles before coprocessor is forced a grant (>=1)
// PORTS
//  clk        in   1    clock, all state on posedge
//  reset      in   1    synchronous, active-low (0 = reset)
//  core_req   in   1    core access request (DM_readEnable | DM_writeEnable)
//  core_we    in   1    core write (1) / read (0)
//  core_addr  in   N    core byte address
//  core_wdata in   N    core store data
//  core_stall out  1    core request present but not granted this cycle
//  core_rdata out  N    read data to core; valid when core_rvalid
//  core_rvalid out 1    1-cycle pulse, cycle after a granted core read
//  cop_ctrl   in   4    [0] req, [1] we, [2] re, [3] lock
//  cop_addr   in   15   coprocessor byte address
//  cop_wdata  in   N    coprocessor store data
//  cop_ack    out  1    coprocessor access granted this cycle
//  cop_rdata  out  N    read data to coprocessor; valid when cop_rvalid
//  cop_rvalid out  1    1-cycle pulse, cycle after a granted coprocessor read
//  mem_address out AW   to dmemip.address
//  mem_data   out  N    to dmemip.data
//  mem_wren   out  1    to dmemip.wren
//  mem_rden   out  1    to dmemip.rden
//  mem_q      in   N    from dmemip.q (valid 1 cycle after rden)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, starve_cnt=0, rd_tag=NONE; combinational outputs
//   then follow the rules below with no grant memory; core_rvalid=cop_rvalid=0.
//  Coprocessor request valid iff cop_ctrl[0] & (cop_ctrl[1]|cop_ctrl[2]); [1]&[2] both set => write.
//  States: IDLE, LOCKED.
//   IDLE grant: if cop valid & starve_cnt==STARVE_MAX -> cop; else if core_req -> core;
//     else if cop valid -> cop; else none.
//   IDLE->LOCKED when cop granted with cop_ctrl[3]=1.
//   LOCKED: cop always granted while cop valid & cop_ctrl[3]; core_stall=core_req.
//   LOCKED->IDLE on first cycle cop_ctrl[3]==0 or cop not valid (that cycle arbitrated as IDLE).
//  starve_cnt: +1 (saturating at STARVE_MAX) when cop valid and core granted; cleared when cop
//   granted or cop not requesting.
//  Grant drives mem_*: address = owner addr[AW+2:3]; data = owner wdata; wren = owner write;
//   rden = owner read. No grant -> wren=rden=0, address/data=0. Never both wren and rden.
//  core_stall = core_req & ~core granted (combinational). cop_ack = cop granted (combinational).
//  rd_tag registered: CORE/COP if a read was granted this cycle, else NONE. Next cycle:
//   core_rdata=cop_rdata=mem_q; core_rvalid=(rd_tag==CORE); cop_rvalid=(rd_tag==COP).
//  Back-to-back reads by either owner sustain 1 result per cycle.
//  Reset mid-operation: in-flight read result discarded (no rvalid), lock dropped.
//  Address bits above AW+2 ignored (wrap within dmem); bits [2:0] ignored.
// TESTING
//  1 core read addr 0x18 alone -> mem_rden=1, mem_address=3, no stall; next cycle core_rvalid=1,
//    core_rdata=mem_q; cop_rvalid=0.
//  2 core and cop both request every cycle, STARVE_MAX=4 -> core granted 4 cycles, cop granted
//    5th (core_stall=1, cop_ack=1), pattern repeats.
//  3 cop write lock burst of 3 (ctrl=4'b1011) while core requests -> 3 cop writes consecutive,
//    core_stall=1 throughout; core granted the cycle ctrl[3] drops.
//  4 alternating core read / cop read back-to-back -> rvalid pulses alternate to correct owner,
//    data matches mem_q of each following cycle.
//  5 reset=0 asserted cycle after granted cop read -> no cop_rvalid, state IDLE, starve_cnt=0.
//  6 cop_ctrl=4'b0001 (req, no we/re) -> treated as no request, cop_ack=0, no mem access.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path and the
// coprocessor IO port, and steers the one-cycle-latency read data back to its owner.
module dmem_port_arbiter #(
    parameter int N          = 64,
    parameter int AW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [N-1:0]  core_addr,
    input  logic [N-1:0]  core_wdata,
    output logic          core_stall,
    output logic [N-1:0]  core_rdata,
    output logic          core_rvalid,
    input  logic [3:0]    cop_ctrl,
    input  logic [14:0]   cop_addr,
    input  logic [N-1:0]  cop_wdata,
    output logic          cop_ack,
    output logic [N-1:0]  cop_rdata,
    output logic          cop_rvalid,
    output logic [AW-1:0] mem_address,
    output logic [N-1:0]  mem_data,
    output logic          mem_wren,
    output logic          mem_rden,
    input  logic [N-1:0]  mem_q
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic {IDLE, LOCKED} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_CORE, TAG_COP} tag_t;

    state_t        state, state_next;
    tag_t          rd_tag, rd_tag_next;
    logic [CW-1:0] starve_cnt, starve_next;
    logic          cop_valid, cop_write, cop_lock;
    logic          grant_core, grant_cop;

    // Only word-address bits reach the memory; the rest are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr[N-1:AW+3], core_addr[2:0],
                                cop_addr[14:AW+3], cop_addr[2:0]};

    // we+re together is a write, so the write bit alone decides direction.
    assign cop_valid = cop_ctrl[0] & (cop_ctrl[1] | cop_ctrl[2]);
    assign cop_write = cop_ctrl[1];
    assign cop_lock  = cop_ctrl[3];

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        grant_core  = 1'b0;
        grant_cop   = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        mem_rden    = 1'b0;
        rd_tag_next = TAG_NONE;
        starve_next = starve_cnt;

        if (state == LOCKED && cop_valid && cop_lock)
            grant_cop = 1'b1;
        else if (cop_valid && starve_cnt == STARVE_LIM)
            grant_cop = 1'b1;
        else if (core_req)
            grant_core = 1'b1;
        else if (cop_valid)
            grant_cop = 1'b1;

        if (grant_core) begin
            mem_address = core_addr[AW+2:3];
            mem_data    = core_wdata;
            mem_wren    = core_we;
            mem_rden    = ~core_we;
            rd_tag_next = core_we ? TAG_NONE : TAG_CORE;
        end else if (grant_cop) begin
            mem_address = cop_addr[AW+2:3];
            mem_data    = cop_wdata;
            mem_wren    = cop_write;
            mem_rden    = ~cop_write;
            rd_tag_next = cop_write ? TAG_NONE : TAG_COP;
        end

        // Leaving the lock is simply any cycle without a locked coprocessor grant.
        state_next = (grant_cop && cop_lock) ? LOCKED : IDLE;

        if (!cop_valid || grant_cop)
            starve_next = '0;
        else if (grant_core && starve_cnt != STARVE_LIM)
            starve_next = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state      <= IDLE;
            rd_tag     <= TAG_NONE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            rd_tag     <= rd_tag_next;
            starve_cnt <= starve_next;
        end
    end

    assign core_stall  = core_req & ~grant_core;
    assign cop_ack     = grant_cop;
    assign core_rdata  = mem_q;
    assign cop_rdata   = mem_q;
    assign core_rvalid = (rd_tag == TAG_CORE);
    assign cop_rvalid  = (rd_tag == TAG_COP);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised bench for dmem_port_arbiter: a behavioural owner/memory model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dmem_port_arbiter;

    localparam int N  = 64;
    localparam int AW = 8;
    localparam int SM = 4;
    localparam logic [N-1:0] K3 = 64'h1111_2222_3333_4444;
    localparam logic [N-1:0] WA = 64'hAAAA_0000_0000_0001;
    localparam logic [N-1:0] WB = 64'hBBBB_0000_0000_0002;
    localparam logic [N-1:0] WC = 64'hCCCC_0000_0000_0003;

    logic          clk, reset;
    logic          core_req, core_we, core_stall, core_rvalid;
    logic [N-1:0]  core_addr, core_wdata, core_rdata;
    logic [3:0]    cop_ctrl;
    logic [14:0]   cop_addr;
    logic [N-1:0]  cop_wdata, cop_rdata;
    logic          cop_ack, cop_rvalid;
    logic [AW-1:0] mem_address;
    logic [N-1:0]  mem_data, mem_q;
    logic          mem_wren, mem_rden;

    int errors = 0;
    int checks = 0;

    dmem_port_arbiter #(.N(N), .AW(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
        .core_rvalid(core_rvalid),
        .cop_ctrl(cop_ctrl), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
        .cop_ack(cop_ack), .cop_rdata(cop_rdata), .cop_rvalid(cop_rvalid),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_rden(mem_rden), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for dmemip, driven only by the DUT's memory port.
    logic [N-1:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) mem_q <= ram[mem_address];
    end

    // Model state: lock flag, lost-cycle count, owner of the read in flight (0 none, 1 core, 2 cop).
    logic [N-1:0] mram [0:255];
    bit           m_locked = 0;
    int           m_starve = 0;
    int           m_pend   = 0;
    logic [N-1:0] m_pend_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Who owns the memory this cycle, and what access they make.
    task automatic expect_access(output int own, output int addr, output bit we,
                                 output logic [N-1:0] data);
        bit cv;
        cv   = cop_ctrl[0] && (cop_ctrl[1] || cop_ctrl[2]);
        own  = 0;
        addr = 0;
        we   = 0;
        data = '0;
        if (cv && m_locked && cop_ctrl[3]) own = 2;
        else if (cv && m_starve == SM)     own = 2;
        else if (core_req)                 own = 1;
        else if (cv)                       own = 2;
        if (own == 1) begin
            addr = int'((core_addr / 8) % 256);
            we   = core_we;
            data = core_wdata;
        end else if (own == 2) begin
            addr = int'((cop_addr / 8) % 256);
            we   = cop_ctrl[1];
            data = cop_wdata;
        end
    endtask

    always @(posedge clk) begin : model_update
        int own, addr;
        bit we, cv;
        logic [N-1:0] data;
        expect_access(own, addr, we, data);
        cv = cop_ctrl[0] && (cop_ctrl[1] || cop_ctrl[2]);
        m_pend = 0;
        if (own != 0) begin
            if (we) mram[addr] = data;
            else begin
                m_pend      = own;
                m_pend_data = mram[addr];
            end
        end
        if (!reset) begin
            m_locked = 0;
            m_starve = 0;
            m_pend   = 0;
        end else begin
            m_locked = (own == 2) && cop_ctrl[3];
            if (!cv || own == 2)              m_starve = 0;
            else if (own == 1 && m_starve < SM) m_starve++;
        end
    end

    always @(negedge clk) begin : compare
        int own, addr;
        bit we;
        logic [N-1:0] data;
        expect_access(own, addr, we, data);
        check("mem_wren",    mem_wren,    64'(own != 0 && we));
        check("mem_rden",    mem_rden,    64'(own != 0 && !we));
        check("mem_address", mem_address, 64'(addr));
        check("mem_data",    mem_data,    data);
        check("core_stall",  core_stall,  64'(core_req && own != 1));
        check("cop_ack",     cop_ack,     64'(own == 2));
        check("core_rvalid", core_rvalid, 64'(m_pend == 1));
        check("cop_rvalid",  cop_rvalid,  64'(m_pend == 2));
        if (m_pend == 1) check("core_rdata", core_rdata, m_pend_data);
        if (m_pend == 2) check("cop_rdata",  cop_rdata,  m_pend_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] v;
        reset = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        cop_ctrl = '0; cop_addr = '0; cop_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            v = {$urandom, $urandom};
            ram[i]  = v;
            mram[i] = v;
        end
        ram[3]  = K3;
        mram[3] = K3;

        repeat (3) tick();
        #1;
        check("rst_core_rvalid", core_rvalid, 0);
        check("rst_cop_rvalid",  cop_rvalid,  0);
        check("rst_mem_rden",    mem_rden,    0);

        // Lone core read of byte 0x18 -> word 3.
        tick(); reset = 1; core_req = 1; core_we = 0; core_addr = 64'h18;
        #1;
        check("t1_rden",  mem_rden,    1);
        check("t1_addr",  mem_address, 3);
        check("t1_stall", core_stall,  0);
        tick(); core_req = 0;
        #1;
        check("t1_rvalid",     core_rvalid, 1);
        check("t1_rdata",      core_rdata,  K3);
        check("t1_cop_rvalid", cop_rvalid,  0);

        // Both request every cycle: cop wins every fifth cycle.
        tick(); core_req = 1; core_addr = 64'h40; cop_ctrl = 4'b0101; cop_addr = 15'h80;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t2_cop_ack", cop_ack,    64'(i == 4 || i == 9));
            check("t2_stall",   core_stall, 64'(i == 4 || i == 9));
            tick();
        end

        // Locked write burst of three, then core wins once the lock drops.
        core_req = 0; cop_ctrl = 4'b1011; cop_addr = 15'h100; cop_wdata = WA;
        #1;
        check("t3_ack0",  cop_ack,  1);
        check("t3_wren0", mem_wren, 1);
        tick(); core_req = 1; cop_addr = 15'h108; cop_wdata = WB;
        #1;
        check("t3_ack1",   cop_ack,    1);
        check("t3_stall1", core_stall, 1);
        tick(); cop_addr = 15'h110; cop_wdata = WC;
        #1;
        check("t3_ack2",   cop_ack,    1);
        check("t3_stall2", core_stall, 1);
        tick(); cop_ctrl = 4'b0011;
        #1;
        check("t3_unlock_stall", core_stall, 0);
        check("t3_unlock_ack",   cop_ack,    0);
        tick(); cop_ctrl = 4'b0000; core_req = 0;

        // Alternating core / cop reads of the words just written.
        tick(); core_req = 1; core_we = 0; core_addr = 64'h100;
        tick(); core_req = 0; cop_ctrl = 4'b0101; cop_addr = 15'h108;
        #1;
        check("t4_core_rvalid", core_rvalid, 1);
        check("t4_core_rdata",  core_rdata,  WA);
        tick(); cop_ctrl = 4'b0000; core_req = 1; core_addr = 64'h110;
        #1;
        check("t4_cop_rvalid",  cop_rvalid,  1);
        check("t4_cop_rdata",   cop_rdata,   WB);
        check("t4_core_idle",   core_rvalid, 0);
        tick(); core_req = 0;
        #1;
        check("t4_core_rvalid2", core_rvalid, 1);
        check("t4_core_rdata2",  core_rdata,  WC);

        // Reset lands on the edge that would capture a locked cop read.
        tick(); cop_ctrl = 4'b1101; cop_addr = 15'h0; reset = 0;
        #1;
        check("t5_ack", cop_ack, 1);
        tick(); reset = 1; core_req = 1; core_we = 0; core_addr = 64'h8;
        #1;
        check("t5_no_rvalid", cop_rvalid, 0);
        check("t5_unlocked",  core_stall, 0);
        check("t5_no_ack",    cop_ack,    0);

        // req without we/re is no request at all.
        tick(); core_req = 0; cop_ctrl = 4'b0001; cop_addr = 15'h7ff8;
        #1;
        check("t6_ack",  cop_ack,     0);
        check("t6_rden", mem_rden,    0);
        check("t6_wren", mem_wren,    0);
        check("t6_addr", mem_address, 0);

        for (int i = 0; i < 800; i++) begin
            tick();
            reset      = ($urandom_range(0, 59) != 0);
            core_req   = ($urandom_range(0, 9) < 7);
            core_we    = $urandom_range(0, 1) != 0;
            core_addr  = {$urandom, $urandom};
            core_wdata = {$urandom, $urandom};
            cop_ctrl   = 4'($urandom);
            if ($urandom_range(0, 3) != 0) cop_ctrl[0] = 1'b1;
            cop_addr   = 15'($urandom);
            cop_wdata  = {$urandom, $urandom};
        end
        tick(); reset = 1; core_req = 0; cop_ctrl = '0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
